// File: rtl/i2c_cfg_pkg.sv
// Shared framing widths, default sensor address and FSM encoding for the I2C command arbiter.
// Pure declarations: no latency, no flow control.
package i2c_cfg_pkg;

  localparam logic [7:0] SLAVE_ADDR_DEF = 8'hBA;
  localparam int         PAYLOAD_W      = 24;
  localparam int         FRAME_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_FINISH
  } arb_state_t;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0]           addr,
                                                     input logic [PAYLOAD_W-1:0] payload);
    return {addr, payload};
  endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_if.sv
// Requester and controller handshake bundle of the arbiter; slave = arbiter view, master = environment view.
// Wires only: no latency; requesters are held off by keeping iREQ high until their oDONE pulse.
interface i2c_cmd_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import i2c_cfg_pkg::*;

  logic [NUM_REQ-1:0]           iREQ;
  logic [NUM_REQ*PAYLOAD_W-1:0] iREQ_DATA;
  logic [NUM_REQ-1:0]           oDONE;
  logic [NUM_REQ-1:0]           oERR;
  logic                         oBUSY;
  logic [7:0]                   oERR_CNT;
  logic                         oI2C_CE;
  logic [FRAME_W-1:0]           oI2C_DATA;
  logic                         oI2C_GO;
  logic                         iI2C_END;
  logic                         iI2C_ACK;

  modport slave (
    input  iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
    output oDONE, oERR, oBUSY, oERR_CNT, oI2C_CE, oI2C_DATA, oI2C_GO
  );

  modport master (
    output iREQ, iREQ_DATA, iI2C_END, iI2C_ACK,
    input  oDONE, oERR, oBUSY, oERR_CNT, oI2C_CE, oI2C_DATA, oI2C_GO
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request scanning upward from ptr+1 with wrap; one-hot and index out.
// Combinational, zero latency; no flow control of its own.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             hit
);

  int cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!hit && req[IDX_W'(cand)]) begin
        hit                 = 1'b1;
        gnt[IDX_W'(cand)]   = 1'b1;
        gnt_idx             = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C controller among NUM_REQ register writers: round-robin grant, NACK retry, END timeout.
// Grant 1 cycle after request, GO on the first tick after grant; losers wait with iREQ held until oDONE.
module i2c_cmd_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int         NUM_REQ       = 4,
  parameter logic [7:0] SLAVE_ADDR    = SLAVE_ADDR_DEF,
  parameter int         CLK_FREQ      = 50000000,
  parameter int         I2C_FREQ      = 20000,
  parameter int         MAX_RETRY     = 3,
  parameter int         TIMEOUT_TICKS = 255
) (
  input  logic             iCLK,
  input  logic             iRST,
  i2c_cmd_arbiter_if.slave bus
);

  localparam int          DIV       = CLK_FREQ / I2C_FREQ;
  localparam int          IDX_W     = $clog2(NUM_REQ);
  localparam logic [31:0] DIV_LAST  = 32'(DIV - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRY);

  arb_state_t             state_q, state_nxt;
  logic [31:0]            div_q;
  logic                   tick;
  logic [IDX_W-1:0]       ptr_q;
  logic [NUM_REQ-1:0]     win_oh;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_hit;
  logic [NUM_REQ-1:0]     gnt_oh_q;
  logic [IDX_W-1:0]       gnt_idx_q;
  logic [3:0]             retry_q;
  logic [15:0]            to_q;
  logic                   go_q;
  logic                   busy_q;
  logic                   err_q;
  logic [7:0]             err_cnt_q;
  logic [FRAME_W-1:0]     data_q;
  logic [PAYLOAD_W-1:0]   payload_sel;

  logic win_ld, grant_ld, go_set, go_clr, to_inc, retry_inc, fail_set;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 32'd1;
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (bus.iREQ),
    .ptr     (ptr_q),
    .gnt     (win_oh),
    .gnt_idx (win_idx),
    .hit     (win_hit)
  );

  always_comb begin
    payload_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_q == IDX_W'(i)) payload_sel = bus.iREQ_DATA[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    win_ld    = 1'b0;
    grant_ld  = 1'b0;
    go_set    = 1'b0;
    go_clr    = 1'b0;
    to_inc    = 1'b0;
    retry_inc = 1'b0;
    fail_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_hit) begin
          win_ld    = 1'b1;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        grant_ld  = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (tick) begin
          go_set    = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          if (bus.iI2C_END && !bus.iI2C_ACK) begin
            go_clr    = 1'b1;
            state_nxt = ST_FINISH;
          end else if (bus.iI2C_END || to_q == TO_LAST) begin
            // NACK and timeout are handled alike: drop GO, then retry or give up.
            go_clr = 1'b1;
            if (retry_q < RETRY_LIM) begin
              retry_inc = 1'b1;
              state_nxt = ST_GAP;
            end else begin
              fail_set  = 1'b1;
              state_nxt = ST_FINISH;
            end
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick) state_nxt = ST_ISSUE;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      gnt_oh_q  <= '0;
      gnt_idx_q <= '0;
      retry_q   <= '0;
      to_q      <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      data_q    <= '0;
    end else begin
      if (win_ld) begin
        gnt_oh_q  <= win_oh;
        gnt_idx_q <= win_idx;
      end
      if (grant_ld) begin
        data_q  <= make_frame(SLAVE_ADDR, payload_sel);
        ptr_q   <= gnt_idx_q;
        retry_q <= '0;
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
      end
      if (go_set) begin
        go_q <= 1'b1;
        to_q <= '0;
      end
      if (go_clr)    go_q    <= 1'b0;
      if (to_inc)    to_q    <= to_q + 16'd1;
      if (retry_inc) retry_q <= retry_q + 4'd1;
      if (fail_set)  err_q   <= 1'b1;
      if (state_q == ST_FINISH) begin
        busy_q <= 1'b0;
        if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.oI2C_CE   = tick;
  assign bus.oI2C_GO   = go_q;
  assign bus.oI2C_DATA = data_q;
  assign bus.oBUSY     = busy_q;
  assign bus.oERR_CNT  = err_cnt_q;
  assign bus.oDONE     = (state_q == ST_FINISH) ? gnt_oh_q : '0;
  assign bus.oERR      = (state_q == ST_FINISH && err_q) ? gnt_oh_q : '0;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: controller model answers END 3 ticks after GO; a queue of expected completions
// is filled when requests are raised and drained as oDONE pulses appear.
module tb_i2c_cmd_arbiter;
  import i2c_cfg_pkg::*;

  localparam int NREQ = 4;

  typedef struct packed {
    logic [3:0]  idx;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  always #5 iCLK = ~iCLK;

  i2c_cmd_arbiter_if #(.NUM_REQ(NREQ)) bus();

  i2c_cmd_arbiter #(
    .NUM_REQ       (NREQ),
    .SLAVE_ADDR    (8'hBA),
    .CLK_FREQ      (80000),
    .I2C_FREQ      (20000),
    .MAX_RETRY     (3),
    .TIMEOUT_TICKS (8)
  ) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus.slave)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // controller model configuration (written by the tests only)
  bit never_end   = 1'b0;
  bit always_nack = 1'b0;
  int nack_first  = 0;
  int bfm_epoch   = 0;
  // controller model state
  int bfm_seen    = 0;
  int ends_issued = 0;
  int tcnt        = 0;

  always @(negedge iCLK) begin
    if (bfm_seen != bfm_epoch) begin
      bfm_seen    = bfm_epoch;
      ends_issued = 0;
    end
    if (iRST || !bus.oI2C_GO) begin
      tcnt         = 0;
      bus.iI2C_END = 1'b0;
      bus.iI2C_ACK = 1'b0;
    end else if (bus.oI2C_CE && !bus.iI2C_END) begin
      tcnt++;
      if (tcnt == 3 && !never_end) begin
        bus.iI2C_END = 1'b1;
        bus.iI2C_ACK = always_nack || (ends_issued < nack_first);
        ends_issued++;
      end
    end
  end

  // GO monitor: attempts, low ticks between attempts, high ticks per attempt
  int   mon_epoch = 0;
  int   mon_seen  = 0;
  int   go_rises  = 0;
  int   min_low   = 999;
  int   min_high  = 999;
  int   max_high  = 0;
  int   hi_t      = 0;
  int   lo_t      = 0;
  logic go_prev   = 1'b0;

  always @(negedge iCLK) begin
    if (mon_seen != mon_epoch) begin
      mon_seen = mon_epoch;
      go_rises = 0;
      min_low  = 999;
      min_high = 999;
      max_high = 0;
      hi_t     = 0;
      lo_t     = 0;
    end
    if (bus.oI2C_GO === 1'b1 && go_prev !== 1'b1) begin
      if (go_rises > 0 && lo_t < min_low) min_low = lo_t;
      go_rises++;
      hi_t = 0;
    end
    if (bus.oI2C_GO !== 1'b1 && go_prev === 1'b1) begin
      if (hi_t < min_high) min_high = hi_t;
      if (hi_t > max_high) max_high = hi_t;
      lo_t = 0;
    end
    if (bus.oI2C_CE === 1'b1) begin
      if (bus.oI2C_GO === 1'b1) hi_t++;
      else                      lo_t++;
    end
    go_prev = bus.oI2C_GO;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need $finish");
    $fatal(1, "watchdog");
  end

  task automatic collect_done(input int budget, output int idx, output logic [NREQ-1:0] done_v,
                              output logic [NREQ-1:0] err_v, output logic [31:0] data,
                              output logic busy, output bit timed_out);
    timed_out = 1'b1;
    idx       = 0;
    done_v    = '0;
    err_v     = '0;
    data      = '0;
    busy      = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iCLK);
      if (bus.oDONE !== '0) begin
        done_v    = bus.oDONE;
        err_v     = bus.oERR;
        data      = bus.oI2C_DATA;
        busy      = bus.oBUSY;
        timed_out = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) if (bus.oDONE[i]) idx = i;
        return;
      end
    end
  endtask

  task automatic push_exp(input int idx, input logic err, input logic [23:0] payload);
    exp_t e;
    e.idx  = 4'(idx);
    e.err  = err;
    e.data = {8'hBA, payload};
    sb.push_back(e);
    bus.iREQ_DATA[idx*24 +: 24] = payload;
  endtask

  task automatic test_reset();
    int gap;
    repeat (2) @(negedge iCLK);
    checks++;
    if (bus.oI2C_GO !== 1'b0 || bus.oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_go_busy: got go=%b busy=%b, need 0 0", bus.oI2C_GO, bus.oBUSY);
    end
    checks++;
    if (bus.oDONE !== 4'b0 || bus.oERR !== 4'b0) begin
      errors++;
      $display("FAIL reset_done_err: got done=%b err=%b, need 0000 0000", bus.oDONE, bus.oERR);
    end
    checks++;
    if (bus.oERR_CNT !== 8'h00 || bus.oI2C_DATA !== 32'h0 || bus.oI2C_CE !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt_data_ce: got cnt=%h data=%h ce=%b, need 00 00000000 0",
               bus.oERR_CNT, bus.oI2C_DATA, bus.oI2C_CE);
    end
    iRST = 1'b0;
    gap  = 0;
    for (int c = 0; c < 20 && bus.oI2C_CE !== 1'b1; c++) @(negedge iCLK);
    for (int c = 0; c < 20; c++) begin
      @(negedge iCLK);
      gap++;
      if (bus.oI2C_CE === 1'b1) break;
    end
    checks++;
    if (gap != 4) begin
      errors++;
      $display("FAIL tick_period: got %0d cycles between ticks, need 4", gap);
    end
  endtask

  task automatic test_two_requesters();
    int idx; logic [NREQ-1:0] dv, ev, need_v; logic [31:0] dat; logic bsy; bit to; exp_t e;
    mon_epoch++;
    push_exp(0, 1'b0, 24'h20C000);
    push_exp(2, 1'b0, 24'h123456);
    bus.iREQ = 4'b0101;
    for (int n = 0; n < 2; n++) begin
      collect_done(2000, idx, dv, ev, dat, bsy, to);
      checks++;
      if (to || sb.size() == 0) begin
        errors++;
        $display("FAIL two_done_%0d: got timeout=%0d pending=%0d, need a done", n, to, sb.size());
        sb.delete(); bus.iREQ = '0;
        return;
      end
      e = sb.pop_front();
      need_v = '0; need_v[e.idx] = 1'b1;
      if (dv !== need_v || ev !== 4'b0) begin
        errors++;
        $display("FAIL two_done_%0d: got done=%b err=%b, need %b 0000", n, dv, ev, need_v);
      end
      checks++;
      if (dat !== e.data || bsy !== 1'b1) begin
        errors++;
        $display("FAIL two_data_%0d: got data=%h busy=%b, need %h 1", n, dat, bsy, e.data);
      end
      bus.iREQ[idx] = 1'b0;
      @(negedge iCLK);
      checks++;
      if (bus.oBUSY !== 1'b0) begin
        errors++;
        $display("FAIL two_busy_clear_%0d: got busy=%b, need 0", n, bus.oBUSY);
      end
    end
    checks++;
    if (go_rises != 2) begin
      errors++;
      $display("FAIL two_go_count: got %0d GO pulses, need 2", go_rises);
    end
  endtask

  task automatic test_single();
    int idx; logic [NREQ-1:0] dv, ev; logic [31:0] dat; logic bsy; bit to; exp_t e;
    mon_epoch++;
    push_exp(1, 1'b0, 24'h0907C0);
    bus.iREQ = 4'b0010;
    collect_done(2000, idx, dv, ev, dat, bsy, to);
    checks++;
    if (to || sb.size() == 0) begin
      errors++;
      $display("FAIL single_done: got timeout=%0d, need done", to);
      sb.delete(); bus.iREQ = '0;
      return;
    end
    e = sb.pop_front();
    bus.iREQ[idx] = 1'b0;
    if (dv !== 4'b0010 || ev !== 4'b0000 || dat !== e.data) begin
      errors++;
      $display("FAIL single_done: got done=%b err=%b data=%h, need 0010 0000 %h", dv, ev, dat, e.data);
    end
    @(negedge iCLK);
    checks++;
    if (go_rises != 1 || bus.oERR_CNT !== 8'd0) begin
      errors++;
      $display("FAIL single_go_cnt: got go=%0d errcnt=%0d, need 1 0", go_rises, bus.oERR_CNT);
    end
  endtask

  task automatic test_nack_retry();
    int idx; logic [NREQ-1:0] dv, ev; logic [31:0] dat; logic bsy; bit to; exp_t e;
    mon_epoch++;
    nack_first = 2;
    bfm_epoch++;
    push_exp(3, 1'b0, 24'hAABBCC);
    bus.iREQ = 4'b1000;
    collect_done(3000, idx, dv, ev, dat, bsy, to);
    checks++;
    if (to || sb.size() == 0) begin
      errors++;
      $display("FAIL nack_done: got timeout=%0d, need done", to);
      sb.delete(); bus.iREQ = '0;
      return;
    end
    e = sb.pop_front();
    bus.iREQ[idx] = 1'b0;
    if (dv !== 4'b1000 || ev !== 4'b0000 || dat !== e.data) begin
      errors++;
      $display("FAIL nack_done: got done=%b err=%b data=%h, need 1000 0000 %h", dv, ev, dat, e.data);
    end
    checks++;
    if (go_rises != 3 || min_low < 1) begin
      errors++;
      $display("FAIL nack_go: got go=%0d min_low_ticks=%0d, need 3 and >=1", go_rises, min_low);
    end
    nack_first = 0;
  endtask

  task automatic test_all_nack();
    int idx; logic [NREQ-1:0] dv, ev; logic [31:0] dat; logic bsy; bit to; exp_t e;
    mon_epoch++;
    always_nack = 1'b1;
    push_exp(2, 1'b1, 24'h01FF02);
    bus.iREQ = 4'b0100;
    collect_done(3000, idx, dv, ev, dat, bsy, to);
    checks++;
    if (to || sb.size() == 0) begin
      errors++;
      $display("FAIL allnack_done: got timeout=%0d, need done", to);
      sb.delete(); bus.iREQ = '0; always_nack = 1'b0;
      return;
    end
    e = sb.pop_front();
    bus.iREQ[idx] = 1'b0;
    if (dv !== 4'b0100 || ev !== 4'b0100 || dat !== e.data) begin
      errors++;
      $display("FAIL allnack_done: got done=%b err=%b data=%h, need 0100 0100 %h", dv, ev, dat, e.data);
    end
    @(negedge iCLK);
    checks++;
    if (go_rises != 4 || bus.oERR_CNT !== 8'd1) begin
      errors++;
      $display("FAIL allnack_go_cnt: got go=%0d errcnt=%0d, need 4 1", go_rises, bus.oERR_CNT);
    end
    always_nack = 1'b0;
  endtask

  task automatic test_timeout();
    int idx; logic [NREQ-1:0] dv, ev; logic [31:0] dat; logic bsy; bit to; exp_t e;
    mon_epoch++;
    never_end = 1'b1;
    push_exp(0, 1'b1, 24'h3C0011);
    bus.iREQ = 4'b0001;
    collect_done(4000, idx, dv, ev, dat, bsy, to);
    checks++;
    if (to || sb.size() == 0) begin
      errors++;
      $display("FAIL timeout_done: got timeout=%0d, need done", to);
      sb.delete(); bus.iREQ = '0; never_end = 1'b0;
      return;
    end
    e = sb.pop_front();
    bus.iREQ[idx] = 1'b0;
    if (dv !== 4'b0001 || ev !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_done: got done=%b err=%b, need 0001 0001", dv, ev);
    end
    @(negedge iCLK);
    checks++;
    if (go_rises != 4 || min_high != 8 || max_high != 8) begin
      errors++;
      $display("FAIL timeout_attempts: got go=%0d high_ticks=%0d..%0d, need 4 and 8..8",
               go_rises, min_high, max_high);
    end
    checks++;
    if (bus.oERR_CNT !== 8'd2) begin
      errors++;
      $display("FAIL timeout_errcnt: got %0d, need 2", bus.oERR_CNT);
    end
    never_end = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dones;
    bit seen_go;
    seen_go = 1'b0;
    bus.iREQ_DATA[1*24 +: 24] = 24'h555555;
    bus.iREQ = 4'b0010;
    for (int c = 0; c < 100; c++) begin
      @(negedge iCLK);
      if (bus.oI2C_GO === 1'b1) begin
        seen_go = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen_go) begin
      errors++;
      $display("FAIL midrst_go: got no GO within 100 cycles, need GO");
    end
    #2 iRST = 1'b1;
    #1;
    checks++;
    if (bus.oI2C_GO !== 1'b0 || bus.oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got go=%b busy=%b, need 0 0", bus.oI2C_GO, bus.oBUSY);
    end
    bus.iREQ = '0;
    dones = 0;
    repeat (3) begin
      @(negedge iCLK);
      if (bus.oDONE !== 4'b0) dones++;
    end
    iRST = 1'b0;
    repeat (2) begin
      @(negedge iCLK);
      if (bus.oDONE !== 4'b0) dones++;
    end
    checks++;
    if (dones != 0 || bus.oERR_CNT !== 8'd0) begin
      errors++;
      $display("FAIL midrst_nodone: got %0d done cycles errcnt=%0d, need 0 0", dones, bus.oERR_CNT);
    end
  endtask

  task automatic test_back_to_back();
    int idx; logic [NREQ-1:0] dv, ev, need_v; logic [31:0] dat; logic bsy; bit to; exp_t e;
    mon_epoch++;
    for (int i = 0; i < NREQ; i++) push_exp(i, 1'b0, 24'hA00000 + 24'(i * 24'h010101));
    bus.iREQ = 4'b1111;
    for (int n = 0; n < NREQ; n++) begin
      collect_done(2000, idx, dv, ev, dat, bsy, to);
      checks++;
      if (to || sb.size() == 0) begin
        errors++;
        $display("FAIL b2b_done_%0d: got timeout=%0d, need done", n, to);
        sb.delete(); bus.iREQ = '0;
        return;
      end
      e = sb.pop_front();
      need_v = '0; need_v[e.idx] = 1'b1;
      bus.iREQ[idx] = 1'b0;
      if (dv !== need_v || ev !== 4'b0 || dat !== e.data) begin
        errors++;
        $display("FAIL b2b_done_%0d: got done=%b err=%b data=%h, need %b 0000 %h",
                 n, dv, ev, dat, need_v, e.data);
      end
    end
    checks++;
    if (go_rises != 4) begin
      errors++;
      $display("FAIL b2b_go_count: got %0d, need 4", go_rises);
    end
  endtask

  initial begin
    bus.iREQ      = '0;
    bus.iREQ_DATA = '0;
    test_reset();
    test_two_requesters();
    test_single();
    test_nack_retry();
    test_all_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
